regfile_scoreboard: RTL and testbench

Parametrised successor to the processor's 8×32 register file. It provides two combinational read ports and one clocked write port, with an optional hardwired zero register and optional write-to-read bypass. A per-register pending scoreboard lets the decode stage detect RAW and WAW hazards against in-flight multicycle producers. It sits between decode (read, issue) and writeback (write).

---
 rtl/regfile_scoreboard_if.sv | 24 ++
 rtl/regfile_scoreboard.sv | 43 ++++
 tb/tb_regfile_scoreboard.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode/writeback bus (read ports, write port, issue, scoreboard) of the register file
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0]      read_reg_1, read_reg_2;
  logic [DATA_W-1:0]      read_data_1, read_data_2;
  logic                   read_pending_1, read_pending_2;
  logic [ADDR_W-1:0]      write_reg;
  logic [DATA_W-1:0]      write_data;
  logic                   RegWrite;
  logic                   issue_valid;
  logic [ADDR_W-1:0]      issue_reg;
  logic                   issue_ready;
  logic [2**ADDR_W-1:0]   pending_mask;
  modport master (
    output read_reg_1, read_reg_2, write_reg, write_data, RegWrite, issue_valid, issue_reg,
    input  read_data_1, read_data_2, read_pending_1, read_pending_2, issue_ready, pending_mask
  );
  modport slave (
    input  read_reg_1, read_reg_2, write_reg, write_data, RegWrite, issue_valid, issue_reg,
    output read_data_1, read_data_2, read_pending_1, read_pending_2, issue_ready, pending_mask
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file with optional zero reg and bypass, plus pending scoreboard; ports clk, rst, bus (slave)
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic                  clk,
  input logic                  rst,
  regfile_scoreboard_if.slave  bus
);
  localparam int NUM_REGS = 2**ADDR_W;
  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] pending, pending_nxt, wr_bit, iss_bit;
  logic                wr_eff, byp_1, byp_2, issue_acc;
  always_comb begin
    wr_eff    = bus.RegWrite && !(ZERO_REG != 0 && bus.write_reg == '0);
    byp_1     = BYPASS != 0 && wr_eff && bus.write_reg == bus.read_reg_1;
    byp_2     = BYPASS != 0 && wr_eff && bus.write_reg == bus.read_reg_2;
    bus.read_data_1 = byp_1 ? bus.write_data :
                      (ZERO_REG != 0 && bus.read_reg_1 == '0) ? '0 : mem[bus.read_reg_1];
    bus.read_data_2 = byp_2 ? bus.write_data :
                      (ZERO_REG != 0 && bus.read_reg_2 == '0) ? '0 : mem[bus.read_reg_2];
    bus.read_pending_1 = pending[bus.read_reg_1] && !byp_1;
    bus.read_pending_2 = pending[bus.read_reg_2] && !byp_2;
    bus.issue_ready = !pending[bus.issue_reg] || (wr_eff && bus.write_reg == bus.issue_reg);
    issue_acc = bus.issue_valid && bus.issue_ready && !(ZERO_REG != 0 && bus.issue_reg == '0);
    wr_bit    = {{(NUM_REGS-1){1'b0}}, wr_eff} << bus.write_reg;
    iss_bit   = {{(NUM_REGS-1){1'b0}}, issue_acc} << bus.issue_reg;
    // set after clear: a new producer issued alongside the writeback keeps the register pending
    pending_nxt = (pending & ~wr_bit) | iss_bit;
  end
  assign bus.pending_mask = pending;
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else begin
      pending <= pending_nxt;
      if (wr_eff) mem[bus.write_reg] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of a default instance (a) and a ZERO_REG=1/BYPASS=0 instance (b)
module tb_regfile_scoreboard;
  logic clk = 0, rst = 0;
  logic [2:0]  rr1 = 0, rr2 = 0, wr = 0, ir = 0;
  logic [31:0] wd = 0;
  logic        we = 0, iv = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) a_if ();
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(3)) b_if ();
  assign a_if.read_reg_1 = rr1;
  assign a_if.read_reg_2 = rr2;
  assign a_if.write_reg = wr;
  assign a_if.write_data = wd;
  assign a_if.RegWrite = we;
  assign a_if.issue_valid = iv;
  assign a_if.issue_reg = ir;
  assign b_if.read_reg_1 = rr1;
  assign b_if.read_reg_2 = rr2;
  assign b_if.write_reg = wr;
  assign b_if.write_data = wd;
  assign b_if.RegWrite = we;
  assign b_if.issue_valid = iv;
  assign b_if.issue_reg = ir;
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    we = 0;
    iv = 0;
    rst = 0;
  endtask
  initial begin
    rst = 1;
    tick();
    rst = 0;
    for (int r = 0; r < 8; r++) begin
      rr1 = 3'(r);
      rr2 = 3'(r);
      ir = 3'(r);
      #2;
      chk("rst_a_rd1", a_if.read_data_1, 0);
      chk("rst_a_rd2", a_if.read_data_2, 0);
      chk("rst_b_rd1", b_if.read_data_1, 0);
      chk("rst_a_pend1", a_if.read_pending_1, 0);
      chk("rst_a_rdy", a_if.issue_ready, 1);
      chk("rst_b_rdy", b_if.issue_ready, 1);
    end
    chk("rst_a_mask", a_if.pending_mask, 0);
    chk("rst_b_mask", b_if.pending_mask, 0);
    tick();
    rr1 = 5; rr2 = 5; wr = 5; wd = 32'hDEADBEEF; we = 1;
    #2;
    chk("byp_a_rd1", a_if.read_data_1, 32'hDEADBEEF);
    chk("byp_a_rd2", a_if.read_data_2, 32'hDEADBEEF);
    chk("nobyp_b_rd1", b_if.read_data_1, 0);
    chk("nobyp_b_rd2", b_if.read_data_2, 0);
    tick();
    idle();
    #2;
    chk("wr_a_rd1", a_if.read_data_1, 32'hDEADBEEF);
    chk("wr_b_rd1", b_if.read_data_1, 32'hDEADBEEF);
    chk("wr_b_rd2", b_if.read_data_2, 32'hDEADBEEF);
    rr1 = 0; wr = 0; wd = 32'h1234; we = 1; iv = 1; ir = 0;
    #2;
    chk("z_b_rd1", b_if.read_data_1, 0);
    chk("z_b_rdy", b_if.issue_ready, 1);
    chk("z_a_byp", a_if.read_data_1, 32'h1234);
    tick();
    idle();
    #2;
    chk("z_b_rd1_after", b_if.read_data_1, 0);
    chk("z_b_mask", b_if.pending_mask, 0);
    chk("z_b_rdy_after", b_if.issue_ready, 1);
    chk("z_a_rd1_after", a_if.read_data_1, 32'h1234);
    chk("z_a_mask", a_if.pending_mask, 8'h01);
    rr1 = 3; rr2 = 3; ir = 3; iv = 1;
    #2;
    chk("iss_a_rdy", a_if.issue_ready, 1);
    chk("iss_b_rdy", b_if.issue_ready, 1);
    tick();
    #2;
    chk("iss_a_pend1", a_if.read_pending_1, 1);
    chk("iss_b_pend2", b_if.read_pending_2, 1);
    chk("iss2_a_rdy", a_if.issue_ready, 0);
    chk("iss2_b_rdy", b_if.issue_ready, 0);
    tick();
    #2;
    chk("hold_a_mask", a_if.pending_mask, 8'h09);
    chk("hold_b_mask", b_if.pending_mask, 8'h08);
    wr = 3; wd = 32'hAA; we = 1;
    #2;
    chk("wb_a_rdy", a_if.issue_ready, 1);
    chk("wb_b_rdy", b_if.issue_ready, 1);
    chk("wb_a_pend1", a_if.read_pending_1, 0);
    chk("wb_b_pend1", b_if.read_pending_1, 1);
    tick();
    idle();
    #2;
    chk("acc_a_mask", a_if.pending_mask, 8'h09);
    chk("acc_b_mask", b_if.pending_mask, 8'h08);
    chk("acc_a_rd1", a_if.read_data_1, 32'hAA);
    chk("acc_b_rd1", b_if.read_data_1, 32'hAA);
    wr = 3; wd = 32'h55; we = 1; ir = 3; iv = 1;
    tick();
    idle();
    #2;
    chk("wi_a_rd1", a_if.read_data_1, 32'h55);
    chk("wi_b_rd1", b_if.read_data_1, 32'h55);
    chk("wi_a_mask", a_if.pending_mask, 8'h09);
    chk("wi_b_pend1", b_if.read_pending_1, 1);
    wr = 3; wd = 32'h66; we = 1; ir = 1; iv = 1;
    tick();
    idle();
    #2;
    chk("diff_a_mask", a_if.pending_mask, 8'h03);
    chk("diff_b_mask", b_if.pending_mask, 8'h02);
    chk("diff_b_rd1", b_if.read_data_1, 32'h66);
    ir = 2; iv = 1;
    tick();
    ir = 6;
    tick();
    idle();
    #2;
    chk("mid_a_mask", a_if.pending_mask, 8'h47);
    chk("mid_b_mask", b_if.pending_mask, 8'h46);
    rst = 1; wr = 4; wd = 32'h77; we = 1; ir = 5; iv = 1;
    tick();
    idle();
    rr1 = 4; rr2 = 3;
    #2;
    chk("mrst_a_mask", a_if.pending_mask, 0);
    chk("mrst_b_mask", b_if.pending_mask, 0);
    chk("mrst_a_rd1", a_if.read_data_1, 0);
    chk("mrst_b_rd1", b_if.read_data_1, 0);
    chk("mrst_a_rd2", a_if.read_data_2, 0);
    wr = 2; wd = 32'h99; we = 1; rr1 = 2;
    tick();
    idle();
    #2;
    chk("stale_a_rd1", a_if.read_data_1, 32'h99);
    chk("stale_b_rd1", b_if.read_data_1, 32'h99);
    chk("stale_b_mask", b_if.pending_mask, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
